nx_indirect_access_arb: RTL and testbench
=========================================

# nx_indirect_access_arb

Single-port memory arbiter that shares one table SRAM between the hardware datapath requester and the software indirect-access controller. It sits between the indirect-access controller's `sw_*` memory port and the physical memory. The hardware side has priority. A burst limiter and the controller's `sw_yield` request guarantee software forward progress. The block also tracks read returns per requester and keeps a saturating stall counter for hardware.

## Interface
Parameters:
- `N_ADDR_BITS`, default 9: memory address width.
- `N_DATA_BITS`, default 96: memory data width.
- `RD_LATENCY`, default 1: memory read latency in cycles, from `mem_cs` to `mem_rdat`. Legal range 1..3.
- `HW_BURST_MAX`, default 16: maximum consecutive hardware grants while software is pending. Legal range 1..255.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `hw_req` in 1: hardware access request.
- `hw_we` in 1: hardware write enable.
- `hw_add` in N_ADDR_BITS: hardware address.
- `hw_wdat` in N_DATA_BITS: hardware write data.
- `hw_gnt` out 1: hardware access accepted this cycle.
- `hw_rvalid` out 1: hardware read data valid.
- `hw_rdat` out N_DATA_BITS: hardware read data.
- `sw_cs`, `sw_ce`, `sw_we` in 1: software chip select, compare enable and write enable.
- `sw_add` in N_ADDR_BITS: software address.
- `sw_wdat` in N_DATA_BITS: software write data.
- `sw_yield` in 1: software has waited too long and demands priority.
- `sw_grant` out 1: software access accepted this cycle.
- `sw_rdat` out N_DATA_BITS: software read data.
- `mem_cs`, `mem_ce`, `mem_we` out 1: memory chip select, compare enable and write enable.
- `mem_add` out N_ADDR_BITS: memory address.
- `mem_wdat` out N_DATA_BITS: memory write data.
- `mem_rdat` in N_DATA_BITS: memory read data.
- `stat_clr` in 1: synchronous clear of `hw_stall_cnt`.
- `hw_stall_cnt` out 16: count of cycles with `hw_req` high and `hw_gnt` low, saturating at 16'hFFFF.

## Operation
- Priority state machine, one flop, reset to `HW_PRI`.
- In `HW_PRI`:
  - If `hw_req` is high, grant hardware. Otherwise, if `sw_cs` is high, grant software.
- In `SW_PRI`:
  - If `sw_cs` is high, grant software and stall hardware.
  - If `sw_cs` is low, grant hardware if `hw_req` is high.
- Burst counter, 8 bits, reset to 0:
  - Increments on each cycle with `hw_gnt && sw_cs`.
  - Clears on any `sw_grant` and whenever `sw_cs` is low.
- Transition `HW_PRI -> SW_PRI`: when `sw_cs` is high, and `sw_yield` is high or the burst counter equals `HW_BURST_MAX-1` while `hw_gnt` is high.
- Transition `SW_PRI -> HW_PRI`: on `sw_grant`, or when `sw_cs` is low (the controller has abandoned the request after timeout). The burst counter clears on this transition.
- Memory port is combinational from the winner:
  - `mem_cs = hw_gnt | sw_grant`.
  - `mem_we`, `mem_add` and `mem_wdat` are taken from the winner.
  - `mem_ce = sw_grant & sw_ce`; hardware never issues a compare.
- With no grant, `mem_cs`, `mem_ce` and `mem_we` are 0, and `mem_add`/`mem_wdat` hold the `sw_*` values.
- Read-return pipeline: a shift register of depth `RD_LATENCY` carrying {valid, owner}. An entry is pushed for every granted non-write access; compare accesses are tagged as software.
  - On a hardware return: `hw_rvalid = 1` and `hw_rdat = mem_rdat` in that cycle only.
  - On a software return: `mem_rdat` is captured into the `sw_rdat` hold register. `sw_rdat` bypasses to `mem_rdat` in the return cycle and shows the held value otherwise.
- `hw_stall_cnt` increments on `hw_req && !hw_gnt`. `stat_clr` takes precedence over an increment in the same cycle.

## Timing
- Grant latency is 0: grant and memory command appear in the same cycle as the winning request.
- Read data is visible at the requester exactly `RD_LATENCY` cycles after the grant. With `RD_LATENCY=1`, `sw_rdat` is valid in the cycle after `sw_grant`.
- A requester holds its request until it sees its grant. A dropped request is not remembered.
- Simultaneous `hw_req` and `sw_cs` in `HW_PRI` with the burst counter below the limit: hardware wins.
- `sw_yield` and `hw_req` together in `HW_PRI`: hardware still wins that cycle, the state moves to `SW_PRI`, and software wins on the next cycle.
- Software is served within `HW_BURST_MAX+1` cycles of raising `sw_cs`.
- Reset values:
  - State `HW_PRI`, burst counter 0, pipeline empty.
  - `hw_rvalid` 0, `sw_rdat` held value 0, `hw_stall_cnt` 0.
  - While `rst_n` is low, `hw_gnt`, `sw_grant`, `mem_cs`, `mem_ce` and `mem_we` are forced to 0.
- Reset asserted mid-read flushes the pipeline. No `hw_rvalid` appears after reset deassertion.

## Test plan
- Idle, then `sw_cs=1` read at address 9'h1A5 with memory data 96'hABC:
  - `sw_grant=1` and `mem_add=9'h1A5` in the same cycle.
  - `sw_rdat=96'hABC` on the next cycle with `RD_LATENCY=1`.
  - `sw_rdat` holds that value afterwards.
- `hw_req` held continuously and `sw_cs` raised at cycle 0, with `HW_BURST_MAX=16`:
  - Hardware is granted on cycles 0..15.
  - `sw_grant` on cycle 16.
  - Hardware is granted again from cycle 17.
- `hw_req` held continuously and `sw_yield` pulsed at cycle 3 with `sw_cs` high:
  - `sw_grant` on cycle 4.
  - `hw_stall_cnt` increments by 1.
- State is `SW_PRI` and `sw_cs` drops before being granted: return to `HW_PRI` with no software memory access. The pending hardware request is granted that cycle.
- `RD_LATENCY=3`, with a hardware read, a software read and a hardware write granted back-to-back:
  - `hw_rvalid` 3 cycles after the first grant.
  - `sw_rdat` updated 3 cycles after the second grant.
  - No return for the write.
- Reset pulsed one cycle after a hardware read grant: no `hw_rvalid`, `hw_stall_cnt=0`, and `stat_clr` with a simultaneous stall leaves the count at 0.

Source files
------------

// File: rtl/nx_indirect_access_arb_if.sv
// Memory-side bundle shared by the hardware requester, the software
// indirect-access controller and the table SRAM.
//
// Handshake: hw_req / sw_cs act as "valid" and hw_gnt / sw_grant act as
// "ready". A transfer happens in exactly the cycle where both are high. A
// requester keeps its request and command fields stable until it sees its
// grant. A request that is dropped before its grant is forgotten.
//
// Modports:
//   slave  - the arbiter view. It receives requests and mem_rdat, and drives
//            grants, read returns and the memory command.
//   master - the environment view: requesters plus the SRAM.
interface nx_indirect_access_arb_if #(
  parameter int N_ADDR_BITS = 9,
  parameter int N_DATA_BITS = 96
);
  logic                   hw_req;
  logic                   hw_we;
  logic [N_ADDR_BITS-1:0] hw_add;
  logic [N_DATA_BITS-1:0] hw_wdat;
  logic                   hw_gnt;
  logic                   hw_rvalid;
  logic [N_DATA_BITS-1:0] hw_rdat;
  logic                   sw_cs;
  logic                   sw_ce;
  logic                   sw_we;
  logic [N_ADDR_BITS-1:0] sw_add;
  logic [N_DATA_BITS-1:0] sw_wdat;
  logic                   sw_yield;
  logic                   sw_grant;
  logic [N_DATA_BITS-1:0] sw_rdat;
  logic                   mem_cs;
  logic                   mem_ce;
  logic                   mem_we;
  logic [N_ADDR_BITS-1:0] mem_add;
  logic [N_DATA_BITS-1:0] mem_wdat;
  logic [N_DATA_BITS-1:0] mem_rdat;

  modport slave (
    input  hw_req, hw_we, hw_add, hw_wdat,
    input  sw_cs, sw_ce, sw_we, sw_add, sw_wdat, sw_yield,
    input  mem_rdat,
    output hw_gnt, hw_rvalid, hw_rdat,
    output sw_grant, sw_rdat,
    output mem_cs, mem_ce, mem_we, mem_add, mem_wdat
  );

  modport master (
    output hw_req, hw_we, hw_add, hw_wdat,
    output sw_cs, sw_ce, sw_we, sw_add, sw_wdat, sw_yield,
    output mem_rdat,
    input  hw_gnt, hw_rvalid, hw_rdat,
    input  sw_grant, sw_rdat,
    input  mem_cs, mem_ce, mem_we, mem_add, mem_wdat
  );
endinterface

// File: rtl/nx_indirect_access_arb.sv
// Single-port table SRAM arbiter. It sits between the hardware datapath
// requester and the software indirect-access controller. Hardware has
// priority. A burst limiter and sw_yield guarantee that software makes
// forward progress. Read returns are tracked per requester.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   bus (slave)   - hw_*, sw_* and mem_* signals (see the interface file)
//   stat_clr      - synchronous clear of hw_stall_cnt (wins over increment)
//   hw_stall_cnt  - saturating count of cycles with hw_req high and no hw_gnt
//   dbg_state     - priority state (0 = HW_PRI, 1 = SW_PRI)
module nx_indirect_access_arb #(
  parameter int N_ADDR_BITS  = 9,
  parameter int N_DATA_BITS  = 96,
  parameter int RD_LATENCY   = 1,
  parameter int HW_BURST_MAX = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  nx_indirect_access_arb_if.slave       bus,
  input  logic                          stat_clr,
  output logic [15:0]                   hw_stall_cnt,
  output logic                          dbg_state
);

  typedef enum logic {HW_PRI = 1'b0, SW_PRI = 1'b1} pri_e;

  localparam logic [7:0] BURST_LAST = 8'(HW_BURST_MAX - 1);

  pri_e                   state_q, state_d;
  logic [7:0]             burst_q, burst_d;
  logic [RD_LATENCY-1:0]  pipe_vld_q, pipe_vld_d;
  logic [RD_LATENCY-1:0]  pipe_sw_q, pipe_sw_d;
  logic [N_DATA_BITS-1:0] sw_rdat_q, sw_rdat_d;
  logic [15:0]            stall_q, stall_d;

  logic                   hw_gnt;
  logic                   sw_grant;
  logic                   mem_we_w;
  logic [N_ADDR_BITS-1:0] mem_add_w;
  logic                   ret_hw;
  logic                   ret_sw;

  // Arbitration and priority state machine. Grants are gated by rst_n so
  // that no memory command can escape while reset is asserted.
  always_comb begin
    hw_gnt   = 1'b0;
    sw_grant = 1'b0;
    state_d  = state_q;
    burst_d  = burst_q;

    if (rst_n) begin
      case (state_q)
        HW_PRI: begin
          if (bus.hw_req)     hw_gnt   = 1'b1;
          else if (bus.sw_cs) sw_grant = 1'b1;
        end
        SW_PRI: begin
          if (bus.sw_cs)       sw_grant = 1'b1;
          else if (bus.hw_req) hw_gnt   = 1'b1;
        end
        default: ;
      endcase
    end

    // The burst counter counts hardware wins while software waits. It clears
    // whenever software is served or stops asking, which also covers the
    // SW_PRI -> HW_PRI exit.
    if (!bus.sw_cs || sw_grant) burst_d = 8'd0;
    else if (hw_gnt)            burst_d = burst_q + 8'd1;

    case (state_q)
      HW_PRI: begin
        if (bus.sw_cs && (bus.sw_yield || (hw_gnt && burst_q == BURST_LAST)))
          state_d = SW_PRI;
      end
      SW_PRI: begin
        // Software is either served now or has abandoned its request.
        if (sw_grant || !bus.sw_cs) state_d = HW_PRI;
      end
      default: state_d = HW_PRI;
    endcase
  end

  // Memory command is taken combinationally from the winner. With no grant,
  // the address and data fields fall through from the software side.
  assign mem_we_w  = hw_gnt ? bus.hw_we : (sw_grant & bus.sw_we);
  assign mem_add_w = hw_gnt ? bus.hw_add : bus.sw_add;

  assign bus.hw_gnt   = hw_gnt;
  assign bus.sw_grant = sw_grant;
  assign bus.mem_cs   = hw_gnt | sw_grant;
  assign bus.mem_ce   = sw_grant & bus.sw_ce;
  assign bus.mem_we   = mem_we_w;
  assign bus.mem_add  = mem_add_w;
  assign bus.mem_wdat = hw_gnt ? bus.hw_wdat : bus.sw_wdat;

  // Read-return pipeline. Entry 0 is loaded in the grant cycle, and the last
  // entry lines up with mem_rdat RD_LATENCY cycles later. Every non-write
  // software access, compares included, returns to the software side.
  assign ret_hw = pipe_vld_q[RD_LATENCY-1] & ~pipe_sw_q[RD_LATENCY-1];
  assign ret_sw = pipe_vld_q[RD_LATENCY-1] &  pipe_sw_q[RD_LATENCY-1];

  always_comb begin
    pipe_vld_d    = '0;
    pipe_sw_d     = '0;
    pipe_vld_d[0] = (hw_gnt | sw_grant) & ~mem_we_w;
    pipe_sw_d[0]  = sw_grant;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_sw_d[i]  = pipe_sw_q[i-1];
    end
  end

  assign sw_rdat_d     = ret_sw ? bus.mem_rdat : sw_rdat_q;
  assign bus.hw_rvalid = ret_hw;
  assign bus.hw_rdat   = bus.mem_rdat;
  // Bypass lets software see its data in the return cycle itself.
  assign bus.sw_rdat   = ret_sw ? bus.mem_rdat : sw_rdat_q;

  always_comb begin
    stall_d = stall_q;
    if (stat_clr)                                         stall_d = 16'd0;
    else if (bus.hw_req && !hw_gnt && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  assign hw_stall_cnt = stall_q;
  assign dbg_state    = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HW_PRI;
      burst_q    <= 8'd0;
      pipe_vld_q <= '0;
      pipe_sw_q  <= '0;
      sw_rdat_q  <= '0;
      stall_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_sw_q  <= pipe_sw_d;
      sw_rdat_q  <= sw_rdat_d;
      stall_q    <= stall_d;
    end
  end

endmodule

// File: tb/tb_nx_indirect_access_arb.sv
module tb_nx_indirect_access_arb;
  localparam int AW    = 9;
  localparam int DW    = 96;
  localparam int BURST = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shared stimulus for both instances (latency 1 and latency 3).
  logic          r_rst_n, r_hw_req, r_hw_we, r_sw_cs, r_sw_ce, r_sw_we, r_sw_yield, r_stat_clr;
  logic [AW-1:0] r_hw_add, r_sw_add;
  logic [DW-1:0] r_hw_wdat, r_sw_wdat;
  logic [DW-1:0] md0, md1;
  logic [15:0]   cnt0, cnt1;
  logic          st0, st1;

  nx_indirect_access_arb_if #(.N_ADDR_BITS(AW), .N_DATA_BITS(DW)) bus0 ();
  nx_indirect_access_arb_if #(.N_ADDR_BITS(AW), .N_DATA_BITS(DW)) bus1 ();

  assign bus0.hw_req = r_hw_req;   assign bus1.hw_req = r_hw_req;
  assign bus0.hw_we = r_hw_we;     assign bus1.hw_we = r_hw_we;
  assign bus0.hw_add = r_hw_add;   assign bus1.hw_add = r_hw_add;
  assign bus0.hw_wdat = r_hw_wdat; assign bus1.hw_wdat = r_hw_wdat;
  assign bus0.sw_cs = r_sw_cs;     assign bus1.sw_cs = r_sw_cs;
  assign bus0.sw_ce = r_sw_ce;     assign bus1.sw_ce = r_sw_ce;
  assign bus0.sw_we = r_sw_we;     assign bus1.sw_we = r_sw_we;
  assign bus0.sw_add = r_sw_add;   assign bus1.sw_add = r_sw_add;
  assign bus0.sw_wdat = r_sw_wdat; assign bus1.sw_wdat = r_sw_wdat;
  assign bus0.sw_yield = r_sw_yield; assign bus1.sw_yield = r_sw_yield;
  assign bus0.mem_rdat = md0;      assign bus1.mem_rdat = md1;

  nx_indirect_access_arb #(.N_ADDR_BITS(AW), .N_DATA_BITS(DW), .RD_LATENCY(1), .HW_BURST_MAX(BURST)) dut0 (
    .clk(clk), .rst_n(r_rst_n), .bus(bus0), .stat_clr(r_stat_clr), .hw_stall_cnt(cnt0), .dbg_state(st0));
  nx_indirect_access_arb #(.N_ADDR_BITS(AW), .N_DATA_BITS(DW), .RD_LATENCY(3), .HW_BURST_MAX(BURST)) dut1 (
    .clk(clk), .rst_n(r_rst_n), .bus(bus1), .stat_clr(r_stat_clr), .hw_stall_cnt(cnt1), .dbg_state(st1));

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit m_valid = 0;

  // Software is "owed" the next slot after a yield or an exhausted burst.
  bit m_owed;
  int m_streak;
  int m_stall;
  logic [DW-1:0] mem_arr [512];
  logic [DW-1:0] m_hold0, m_hold1;

  // Outstanding reads: data plus due cycle, instance and owner.
  logic [DW-1:0] exp_q[$];
  int            due_q[$];
  int            inst_q[$];
  bit            sw_q[$];

  logic          e_hw_gnt, e_sw_grant, e_mem_cs, e_mem_ce, e_mem_we, e_state;
  logic [AW-1:0] e_mem_add;
  logic [DW-1:0] e_mem_wdat;
  logic [15:0]   e_stall;
  logic          e_rv0, e_rv1;
  logic [DW-1:0] e_rd0, e_rd1, e_sr0, e_sr1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Removes the read due now for instance k and reports it.
  task automatic take_ret(input int k, output bit v, output bit s, output logic [DW-1:0] d);
    v = 0; s = 0; d = '0;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (due_q[i] == cyc && inst_q[i] == k) begin
        v = 1; s = sw_q[i]; d = exp_q[i];
        exp_q.delete(i); due_q.delete(i); inst_q.delete(i); sw_q.delete(i);
      end
    end
  endtask

  task automatic model_step();
    bit gh, gs, we, nxt_owed, v, s;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, d;
    if (!r_rst_n) begin
      m_owed = 0; m_streak = 0; m_stall = 0;
      m_hold0 = '0; m_hold1 = '0;
      exp_q.delete(); due_q.delete(); inst_q.delete(); sw_q.delete();
    end
    gh = 0; gs = 0;
    if (r_rst_n) begin
      if (m_owed) begin gs = r_sw_cs;  gh = !r_sw_cs && r_hw_req; end
      else        begin gh = r_hw_req; gs = !r_hw_req && r_sw_cs; end
    end
    we = gh ? r_hw_we : (gs && r_sw_we);
    a  = gh ? r_hw_add : r_sw_add;
    wd = gh ? r_hw_wdat : r_sw_wdat;
    e_hw_gnt = gh; e_sw_grant = gs; e_mem_cs = gh | gs; e_mem_ce = gs & r_sw_ce;
    e_mem_we = we; e_mem_add = a; e_mem_wdat = wd;
    e_stall = 16'(m_stall); e_state = m_owed;

    take_ret(0, v, s, d);
    md0 = v ? d : rnd_data();
    e_rv0 = v && !s; e_rd0 = md0;
    if (v && s) m_hold0 = d;
    e_sr0 = m_hold0;
    take_ret(1, v, s, d);
    md1 = v ? d : rnd_data();
    e_rv1 = v && !s; e_rd1 = md1;
    if (v && s) m_hold1 = d;
    e_sr1 = m_hold1;

    if ((gh || gs) && !we) begin
      exp_q.push_back(mem_arr[a]); due_q.push_back(cyc + 1); inst_q.push_back(0); sw_q.push_back(gs);
      exp_q.push_back(mem_arr[a]); due_q.push_back(cyc + 3); inst_q.push_back(1); sw_q.push_back(gs);
    end
    if ((gh || gs) && we) mem_arr[a] = wd;

    if (r_rst_n) begin
      nxt_owed = m_owed ? 1'b0 : (r_sw_cs && (r_sw_yield || (gh && m_streak == BURST - 1)));
      m_streak = (!r_sw_cs || gs) ? 0 : m_streak + (gh ? 1 : 0);
      if (r_stat_clr)                          m_stall = 0;
      else if (r_hw_req && !gh && m_stall < 65535) m_stall = m_stall + 1;
      m_owed = nxt_owed;
    end
    m_valid = 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    cyc++;
    r_rst_n = 1; r_hw_req = 0; r_hw_we = 0; r_hw_add = '0; r_hw_wdat = '0;
    r_sw_cs = 0; r_sw_ce = 0; r_sw_we = 0; r_sw_add = '0; r_sw_wdat = '0;
    r_sw_yield = 0; r_stat_clr = 0;
  endtask

  task automatic settle();
    #1 model_step();
  endtask

  task automatic idle();
    tick(); settle();
  endtask

  task automatic hw_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    tick(); r_hw_req = 1; r_hw_we = 1; r_hw_add = a; r_hw_wdat = d; settle();
  endtask

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (m_valid) begin
        chk("hw_gnt0", bus0.hw_gnt, e_hw_gnt);     chk("hw_gnt1", bus1.hw_gnt, e_hw_gnt);
        chk("sw_grant0", bus0.sw_grant, e_sw_grant); chk("sw_grant1", bus1.sw_grant, e_sw_grant);
        chk("mem_cs0", bus0.mem_cs, e_mem_cs);     chk("mem_cs1", bus1.mem_cs, e_mem_cs);
        chk("mem_ce0", bus0.mem_ce, e_mem_ce);     chk("mem_ce1", bus1.mem_ce, e_mem_ce);
        chk("mem_we0", bus0.mem_we, e_mem_we);     chk("mem_we1", bus1.mem_we, e_mem_we);
        chk("mem_add0", bus0.mem_add, e_mem_add);  chk("mem_add1", bus1.mem_add, e_mem_add);
        chk("mem_wdat0", bus0.mem_wdat, e_mem_wdat); chk("mem_wdat1", bus1.mem_wdat, e_mem_wdat);
        chk("stall0", cnt0, e_stall);              chk("stall1", cnt1, e_stall);
        chk("state0", st0, e_state);               chk("state1", st1, e_state);
        chk("hw_rvalid0", bus0.hw_rvalid, e_rv0);  chk("hw_rvalid1", bus1.hw_rvalid, e_rv1);
        if (e_rv0) chk("hw_rdat0", bus0.hw_rdat, e_rd0);
        if (e_rv1) chk("hw_rdat1", bus1.hw_rdat, e_rd1);
        chk("sw_rdat0", bus0.sw_rdat, e_sr0);      chk("sw_rdat1", bus1.sw_rdat, e_sr1);
      end
    end
  end

  // ---------------- directed + random sequences ----------------
  int sgc, hgc, s4, s5;
  logic hg17;

  initial begin
    for (int i = 0; i < 512; i++) mem_arr[i] = rnd_data();
    r_rst_n = 0; r_hw_req = 0; r_hw_we = 0; r_hw_add = '0; r_hw_wdat = '0;
    r_sw_cs = 0; r_sw_ce = 0; r_sw_we = 0; r_sw_add = '0; r_sw_wdat = '0;
    r_sw_yield = 0; r_stat_clr = 0; md0 = '0; md1 = '0;

    // Reset: grants and memory strobes forced low even with requests up.
    tick(); r_rst_n = 0; r_hw_req = 1; r_sw_cs = 1; r_hw_we = 1; r_sw_we = 1; settle();
    #2;
    chk("rst_hw_gnt", bus0.hw_gnt, 1'b0);
    chk("rst_sw_grant", bus0.sw_grant, 1'b0);
    chk("rst_mem_cs", bus1.mem_cs, 1'b0);
    chk("rst_mem_we", bus0.mem_we, 1'b0);
    chk("rst_stall", cnt0, 16'd0);
    repeat (2) begin tick(); r_rst_n = 0; settle(); end

    // Software read of 0x1A5 holding 0xABC.
    hw_wr(9'h1A5, 96'hABC);
    idle();
    tick(); r_sw_cs = 1; r_sw_add = 9'h1A5; settle();
    #2;
    chk("lit_sw_grant", bus0.sw_grant, 1'b1);
    chk("lit_sw_add", bus0.mem_add, 9'h1A5);
    idle(); #2 chk("lit_sw_rdat_l1", bus0.sw_rdat, 96'hABC);
    idle(); #2 chk("lit_sw_rdat_hold", bus0.sw_rdat, 96'hABC);
    idle(); #2 chk("lit_sw_rdat_l3", bus1.sw_rdat, 96'hABC);

    // Burst limit: hw held, sw raised at cycle 0.
    idle();
    sgc = -1; hgc = 0; hg17 = 0;
    for (int i = 0; i < 18; i++) begin
      tick(); r_hw_req = 1; r_hw_add = 9'(i); r_sw_cs = (i <= 16); settle();
      #2;
      if (bus0.sw_grant && sgc < 0) sgc = i;
      if (i < 16 && bus0.hw_gnt) hgc++;
      if (i == 17) hg17 = bus0.hw_gnt;
    end
    chk("lit_burst_sw_cycle", 96'(sgc), 96'd16);
    chk("lit_burst_hw_count", 96'(hgc), 96'd16);
    chk("lit_burst_hw_after", hg17, 1'b1);

    // Yield pulsed at cycle 3.
    idle();
    sgc = -1; s4 = 0; s5 = 0;
    for (int i = 0; i < 6; i++) begin
      tick(); r_hw_req = 1; r_sw_cs = (i <= 4); r_sw_yield = (i == 3); settle();
      #2;
      if (bus0.sw_grant && sgc < 0) sgc = i;
      if (i == 4) s4 = int'(cnt0);
      if (i == 5) s5 = int'(cnt0);
    end
    chk("lit_yield_sw_cycle", 96'(sgc), 96'd4);
    chk("lit_yield_stall_inc", 96'(s5 - s4), 96'd1);

    // SW_PRI entered, then sw_cs dropped: hardware served, state returns.
    tick(); r_hw_req = 1; r_sw_cs = 1; r_sw_yield = 1; settle();
    tick(); r_hw_req = 1; r_hw_add = 9'h055; settle();
    #2;
    chk("lit_drop_state", st0, 1'b1);
    chk("lit_drop_hw_gnt", bus0.hw_gnt, 1'b1);
    chk("lit_drop_sw_grant", bus0.sw_grant, 1'b0);
    chk("lit_drop_add", bus0.mem_add, 9'h055);
    idle(); #2 chk("lit_drop_state_after", st0, 1'b0);

    // Latency 3: hw read, sw read, hw write back-to-back.
    hw_wr(9'h010, 96'h111);
    hw_wr(9'h020, 96'h222);
    tick(); r_hw_req = 1; r_hw_add = 9'h010; settle();
    tick(); r_sw_cs = 1; r_sw_add = 9'h020; settle();
    hw_wr(9'h030, 96'h333);
    idle(); #2;
    chk("lit_l3_hw_rvalid", bus1.hw_rvalid, 1'b1);
    chk("lit_l3_hw_rdat", bus1.hw_rdat, 96'h111);
    idle(); #2;
    chk("lit_l3_sw_rdat", bus1.sw_rdat, 96'h222);
    chk("lit_l3_no_hw", bus1.hw_rvalid, 1'b0);
    idle(); #2 chk("lit_l3_no_wr_ret", bus1.hw_rvalid, 1'b0);

    // Reset one cycle after a hw read grant.
    tick(); r_hw_req = 1; r_hw_add = 9'h040; settle();
    tick(); r_rst_n = 0; r_hw_req = 1; settle();
    #2 chk("lit_rst_stall", cnt0, 16'd0);
    for (int i = 0; i < 4; i++) begin
      idle(); #2;
      chk("lit_rst_no_rv1", bus1.hw_rvalid, 1'b0);
      chk("lit_rst_no_rv0", bus0.hw_rvalid, 1'b0);
    end
    tick(); r_hw_req = 1; r_sw_cs = 1; r_sw_yield = 1; settle();
    tick(); r_hw_req = 1; r_sw_cs = 1; r_stat_clr = 1; settle();
    idle(); #2 chk("lit_clr_wins", cnt0, 16'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      tick();
      r_rst_n    = ($urandom_range(0, 299) != 0);
      r_hw_req   = $urandom_range(0, 1);
      r_hw_we    = $urandom_range(0, 1);
      r_hw_add   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      r_hw_wdat  = rnd_data();
      r_sw_cs    = $urandom_range(0, 1);
      r_sw_ce    = $urandom_range(0, 1);
      r_sw_we    = $urandom_range(0, 1);
      r_sw_add   = AW'($urandom_range(0, 15));
      r_sw_wdat  = rnd_data();
      r_sw_yield = ($urandom_range(0, 7) == 0);
      r_stat_clr = ($urandom_range(0, 29) == 0);
      settle();
    end

    idle();
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
